uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter. Has an internal baud divider, optional parity,
//  1 or 2 stop bits, and a FIFO_DEPTH-word input FIFO, so an upstream producer can

---
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side word interface of uart_tx_fifo, plus a debug view of the transmitter state.
// Valid/ready: a word transfers on every rising edge where i_uart_data_valid && o_uart_ready;
// the producer holds data stable while valid is high and not yet accepted.
interface uart_tx_fifo_if #(
   parameter int N_DATA_BITS = 8
);
   logic                   i_uart_data_valid;
   logic [N_DATA_BITS-1:0] i_uart_data;
   logic                   o_uart_ready;
   logic [2:0]             o_uart_state;

   modport master (
      output i_uart_data_valid,
      output i_uart_data,
      input  o_uart_ready,
      input  o_uart_state
   );

   modport slave (
      input  i_uart_data_valid,
      input  i_uart_data,
      output o_uart_ready,
      output o_uart_state
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with internal baud divider, optional parity, 1/2 stop bits and an
// input FIFO so frames can leave back-to-back while the producer bursts words in.
module uart_tx_fifo #(
   parameter int N_DATA_BITS  = 8,
   parameter int PARITY_MODE  = 0,
   parameter int N_STOP_BITS  = 1,
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        i_uart_clk,
   input  logic                        i_uart_reset,
   input  logic                        i_uart_en,
   uart_tx_fifo_if.slave               s_uart,
   output logic                        o_uart_tx,
   output logic                        o_uart_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_uart_fifo_count
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = $clog2(N_DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(N_DATA_BITS - 1);
   localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(N_STOP_BITS - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [N_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;
   logic [N_DATA_BITS-1:0] r_shift;
   logic                   r_parity;
   logic                   r_tx;
   logic [BAUD_W-1:0]      r_baud;
   logic [IDX_W-1:0]       r_bit_idx;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_can_start;
   logic w_bit_end;
   logic w_tx_nxt;
   logic w_word_parity;

   assign w_full        = (r_count == CNT_FULL);
   assign w_empty       = (r_count == '0);
   assign w_push        = s_uart.i_uart_data_valid && !w_full;
   assign w_can_start   = !w_empty && i_uart_en;
   assign w_bit_end     = (r_baud == BAUD_LAST);
   assign w_word_parity = (PARITY_MODE == 2) ? ~^r_mem[r_rd_ptr] : ^r_mem[r_rd_ptr];

   assign s_uart.o_uart_ready = !w_full;
   assign s_uart.o_uart_state = r_state;
   assign o_uart_tx           = r_tx;
   assign o_uart_busy         = (r_state != S_IDLE);
   assign o_uart_fifo_count   = r_count;

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge i_uart_clk or posedge i_uart_reset) begin
      if (i_uart_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_uart_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_uart.i_uart_data;
   end

   // w_tx_nxt is the line level for the current state; it appears on the pin one cycle later.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (w_can_start) begin
               w_pop       = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_tx_nxt = 1'b0;
            if (w_bit_end) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_tx_nxt = r_shift[0];
            if (w_bit_end && (r_bit_idx == DATA_LAST))
               w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            w_tx_nxt = r_parity;
            if (w_bit_end) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_bit_end && (r_bit_idx == STOP_LAST)) begin
               if (w_can_start) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_uart_clk or posedge i_uart_reset) begin
      if (i_uart_reset) begin
         r_state   <= S_IDLE;
         r_tx      <= 1'b1;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_baud    <= '0;
         r_bit_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_parity <= w_word_parity;
         end else if ((r_state == S_DATA) && w_bit_end) begin
            r_shift <= r_shift >> 1;
         end
         // Every state change restarts the bit timing, including STOP -> START.
         if ((r_state == S_IDLE) || (w_state_nxt != r_state)) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
         end else if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= r_bit_idx + 1'b1;
         end else begin
            r_baud <= r_baud + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 7E2, 8O1) checked cycle-by-cycle
// against frames built from a queue of expected words.
module tb_uart_tx_fifo;
   logic       clk = 1'b0;
   logic       rst;
   logic       ena, enb, enc;
   logic       va, vb, vc;
   logic [7:0] da, dc;
   logic [6:0] db;
   logic       txa, txb, txc;
   logic       busya, busyb, busyc;
   logic [2:0] ca, cb, cc;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_tx_fifo_if #(.N_DATA_BITS(8)) if_a ();
   uart_tx_fifo_if #(.N_DATA_BITS(7)) if_b ();
   uart_tx_fifo_if #(.N_DATA_BITS(8)) if_c ();

   assign if_a.i_uart_data_valid = va;
   assign if_a.i_uart_data       = da;
   assign if_b.i_uart_data_valid = vb;
   assign if_b.i_uart_data       = db;
   assign if_c.i_uart_data_valid = vc;
   assign if_c.i_uart_data       = dc;

   uart_tx_fifo #(.N_DATA_BITS(8), .PARITY_MODE(0), .N_STOP_BITS(1), .CLKS_PER_BIT(4),
                  .FIFO_DEPTH(4)) dut_a (
      .i_uart_clk(clk), .i_uart_reset(rst), .i_uart_en(ena), .s_uart(if_a),
      .o_uart_tx(txa), .o_uart_busy(busya), .o_uart_fifo_count(ca));

   uart_tx_fifo #(.N_DATA_BITS(7), .PARITY_MODE(1), .N_STOP_BITS(2), .CLKS_PER_BIT(4),
                  .FIFO_DEPTH(4)) dut_b (
      .i_uart_clk(clk), .i_uart_reset(rst), .i_uart_en(enb), .s_uart(if_b),
      .o_uart_tx(txb), .o_uart_busy(busyb), .o_uart_fifo_count(cb));

   uart_tx_fifo #(.N_DATA_BITS(8), .PARITY_MODE(2), .N_STOP_BITS(1), .CLKS_PER_BIT(3),
                  .FIFO_DEPTH(4)) dut_c (
      .i_uart_clk(clk), .i_uart_reset(rst), .i_uart_en(enc), .s_uart(if_c),
      .o_uart_tx(txc), .o_uart_busy(busyc), .o_uart_fifo_count(cc));

   function automatic logic get_tx(int s);
      case (s)
         0: return txa;
         1: return txb;
         default: return txc;
      endcase
   endfunction

   function automatic logic get_busy(int s);
      case (s)
         0: return busya;
         1: return busyb;
         default: return busyc;
      endcase
   endfunction

   function automatic logic get_ready(int s);
      case (s)
         0: return if_a.o_uart_ready;
         1: return if_b.o_uart_ready;
         default: return if_c.o_uart_ready;
      endcase
   endfunction

   function automatic logic [2:0] get_cnt(int s);
      case (s)
         0: return ca;
         1: return cb;
         default: return cc;
      endcase
   endfunction

   function automatic logic [2:0] get_state(int s);
      case (s)
         0: return if_a.o_uart_state;
         1: return if_b.o_uart_state;
         default: return if_c.o_uart_state;
      endcase
   endfunction

   task automatic set_valid(int s, logic v);
      case (s)
         0: va = v;
         1: vb = v;
         default: vc = v;
      endcase
   endtask

   task automatic set_data(int s, logic [7:0] w);
      case (s)
         0: da = w;
         1: db = w[6:0];
         default: dc = w;
      endcase
   endtask

   // Starts just after a negedge; drives one word across one posedge, returns at the next negedge.
   task automatic push_word(int s, logic [7:0] w, logic exp_acc);
      set_valid(s, 1'b1);
      set_data(s, w);
      checks++;
      if (get_ready(s) !== exp_acc) begin
         errors++;
         $display("FAIL push_ready dut%0d word %h: ready=%b expected %b", s, w, get_ready(s), exp_acc);
      end
      if (exp_acc) exp_q.push_back(w);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_count(string name, int s, int exp_cnt);
      checks++;
      if (get_cnt(s) !== 3'(exp_cnt)) begin
         errors++;
         $display("FAIL %s dut%0d: count=%0d expected %0d", name, s, get_cnt(s), exp_cnt);
      end
   endtask

   // c counts edges from the pop edge (c=1); tx lags the state by one cycle.
   task automatic check_frame(int s, int nbits, int pmode, int nstop, int cpb, int first_c,
                              logic more);
      logic [7:0] w;
      logic       bits[16];
      logic       p;
      logic       exp_tx, exp_busy;
      int         nb, flen;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL frame_queue dut%0d: no expected word queued, expected at least 1", s);
         return;
      end
      w = exp_q.pop_front();
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p ^= w[i];
      nb = 0;
      bits[nb] = 1'b0;
      nb++;
      for (int i = 0; i < nbits; i++) begin
         bits[nb] = w[i];
         nb++;
      end
      if (pmode != 0) begin
         bits[nb] = (pmode == 2) ? ~p : p;
         nb++;
      end
      for (int i = 0; i < nstop; i++) begin
         bits[nb] = 1'b1;
         nb++;
      end
      flen = nb * cpb;
      for (int c = first_c; c <= flen + 1; c++) begin
         @(negedge clk);
         exp_tx   = (c == 1) ? 1'b1 : bits[(c - 2) / cpb];
         exp_busy = (c <= flen) ? 1'b1 : more;
         checks++;
         if (get_tx(s) !== exp_tx) begin
            errors++;
            $display("FAIL frame_tx dut%0d word %h cycle %0d: tx=%b expected %b", s, w, c,
                     get_tx(s), exp_tx);
         end
         checks++;
         if (get_busy(s) !== exp_busy) begin
            errors++;
            $display("FAIL frame_busy dut%0d word %h cycle %0d: busy=%b expected %b", s, w, c,
                     get_busy(s), exp_busy);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ena = 1'b0; enb = 1'b0; enc = 1'b0;
      va = 1'b0; vb = 1'b0; vc = 1'b0;
      da = '0; db = '0; dc = '0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (get_tx(s) !== 1'b1 || get_ready(s) !== 1'b1 || get_busy(s) !== 1'b0 ||
             get_state(s) !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: tx=%b ready=%b busy=%b state=%0d expected 1 1 0 0",
                     s, get_tx(s), get_ready(s), get_busy(s), get_state(s));
         end
         check_count("reset_count", s, 0);
      end
      rst = 1'b0;
      ena = 1'b1; enb = 1'b1; enc = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_8n1();
      push_word(0, 8'hA5, 1'b1);
      set_valid(0, 1'b0);
      check_frame(0, 8, 0, 1, 4, 1, 1'b0);
      push_word(0, 8'h3C, 1'b1);
      set_valid(0, 1'b0);
      check_frame(0, 8, 0, 1, 4, 1, 1'b0);
   endtask

   task automatic test_parity();
      push_word(1, 8'h35, 1'b1);
      set_valid(1, 1'b0);
      check_frame(1, 7, 1, 2, 4, 1, 1'b0);
      push_word(1, 8'h01, 1'b1);
      set_valid(1, 1'b0);
      check_frame(1, 7, 1, 2, 4, 1, 1'b0);
      push_word(2, 8'h00, 1'b1);
      set_valid(2, 1'b0);
      check_frame(2, 8, 2, 1, 3, 1, 1'b0);
      push_word(2, 8'h07, 1'b1);
      set_valid(2, 1'b0);
      check_frame(2, 8, 2, 1, 3, 1, 1'b0);
   endtask

   task automatic test_fifo_full();
      ena = 1'b0;
      push_word(0, 8'h11, 1'b1);
      check_count("fill_count", 0, 1);
      push_word(0, 8'h22, 1'b1);
      check_count("fill_count", 0, 2);
      push_word(0, 8'h33, 1'b1);
      check_count("fill_count", 0, 3);
      push_word(0, 8'h44, 1'b1);
      check_count("fill_count", 0, 4);
      push_word(0, 8'h55, 1'b0);
      set_valid(0, 1'b0);
      check_count("full_count", 0, 4);
      checks++;
      if (get_ready(0) !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: ready=%b expected 0", get_ready(0));
      end
      ena = 1'b1;
      check_frame(0, 8, 0, 1, 4, 1, 1'b1);
      check_frame(0, 8, 0, 1, 4, 2, 1'b1);
      check_frame(0, 8, 0, 1, 4, 2, 1'b1);
      check_frame(0, 8, 0, 1, 4, 2, 1'b0);
      check_count("drain_count", 0, 0);
   endtask

   task automatic test_full_push_pop();
      ena = 1'b0;
      push_word(0, 8'hA1, 1'b1);
      push_word(0, 8'hA2, 1'b1);
      push_word(0, 8'hA3, 1'b1);
      push_word(0, 8'hA4, 1'b1);
      ena = 1'b1;
      push_word(0, 8'h66, 1'b0);
      set_valid(0, 1'b0);
      check_count("pushpop_count", 0, 3);
      checks++;
      if (get_ready(0) !== 1'b1) begin
         errors++;
         $display("FAIL pushpop_ready: ready=%b expected 1", get_ready(0));
      end
      check_frame(0, 8, 0, 1, 4, 2, 1'b1);
      check_frame(0, 8, 0, 1, 4, 2, 1'b1);
      check_frame(0, 8, 0, 1, 4, 2, 1'b1);
      check_frame(0, 8, 0, 1, 4, 2, 1'b0);
      check_count("pushpop_drain", 0, 0);
   endtask

   task automatic test_enable_gap();
      ena = 1'b0;
      push_word(0, 8'h5A, 1'b1);
      push_word(0, 8'hC3, 1'b1);
      push_word(0, 8'h0F, 1'b1);
      set_valid(0, 1'b0);
      ena = 1'b1;
      fork
         check_frame(0, 8, 0, 1, 4, 1, 1'b0);
         begin
            repeat (10) @(negedge clk);
            ena = 1'b0;
         end
      join
      repeat (6) begin
         @(negedge clk);
         checks++;
         if (get_tx(0) !== 1'b1 || get_busy(0) !== 1'b0) begin
            errors++;
            $display("FAIL en_low_idle: tx=%b busy=%b expected 1 0", get_tx(0), get_busy(0));
         end
      end
      check_count("en_low_count", 0, 2);
      ena = 1'b1;
      check_frame(0, 8, 0, 1, 4, 1, 1'b1);
      check_frame(0, 8, 0, 1, 4, 2, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      ena = 1'b0;
      push_word(0, 8'h00, 1'b1);
      push_word(0, 8'h81, 1'b1);
      set_valid(0, 1'b0);
      ena = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (get_state(0) !== 3'd2 || get_tx(0) !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset: state=%0d tx=%b expected 2 0", get_state(0), get_tx(0));
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (get_tx(0) !== 1'b1 || get_ready(0) !== 1'b1 || get_busy(0) !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: tx=%b ready=%b busy=%b expected 1 1 0", get_tx(0),
                  get_ready(0), get_busy(0));
      end
      check_count("mid_reset_count", 0, 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push_word(0, 8'h96, 1'b1);
      set_valid(0, 1'b0);
      check_frame(0, 8, 0, 1, 4, 1, 1'b0);
      check_count("post_reset_count", 0, 0);
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_fifo_full();
      test_full_push_pop();
      test_enable_gap();
      test_reset_mid_frame();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_queue: %0d words left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
